pedestrian_request_unit: RTL
============================

// Module: pedestrian_request_unit
// PURPOSE
// Kerb-side pedestrian push-button unit; the request side of the controller's pedestrian interface.
// - Drives the controller's pedestrian_btn input.
// - Consumes the controller's walk_light / stop_light outputs.
// - Synchronises and debounces the raw button, then holds a request until the walk phase is served.
// - Drives a WAIT lamp and a walk-elapsed tick display, and flags protocol faults.
// PARAMETERS
// DEBOUNCE_CYCLES  4   consecutive stable synced cycles before the debounced level changes
// TICK_CYCLES      8   clk cycles per walk-display tick
// COUNT_W          4   width of walk_ticks
// TIMEOUT_CYCLES   64  max cycles in WAIT before fault
// LOCKOUT_CYCLES   4   cycles after walk ends during which presses are ignored
// PORTS
// clk             in   1        system clock, all state on posedge
// rst_n           in   1        asynchronous, active-low reset
// btn_raw         in   1        raw push-button, asynchronous, active-high
// walk_light      in   1        from controller: walk phase active
// stop_light      in   1        from controller: pedestrians stopped
// pedestrian_btn  out  1        registered request to controller; level, held until served
// wait_lamp       out  1        high while a request is pending (state WAIT)
// walk_ticks      out  COUNT_W  ticks elapsed in the current walk, saturating
// fault           out  1        sticky protocol/timeout fault
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0; FSM=IDLE; all counters 0; debounced level 0.
// - Input path:
//   - 2-FF synchroniser.
//   - Debounce counter counts cycles where the synced level != btn_db; it clears when they match.
//   - At DEBOUNCE_CYCLES, btn_db toggles. press = btn_db rising edge, a 1-cycle pulse.
// - Latency: btn_raw held high -> pedestrian_btn high DEBOUNCE_CYCLES+3 posedges later, measured
//   from the first edge that samples it high.
// - Glitches shorter than DEBOUNCE_CYCLES produce no press.
// - FSM (2-bit):
//   - IDLE: press -> WAIT. walk_light=1 without a request -> WALK (no fault).
//   - WAIT: pedestrian_btn=1, wait_lamp=1.
//     - walk_light=1 -> WALK; pedestrian_btn drops on that same transition edge.
//     - TIMEOUT_CYCLES elapsed -> fault=1, stay in WAIT, keep requesting.
//     - Further presses are absorbed; the timeout does not restart.
//   - WALK: pedestrian_btn=0, wait_lamp=0.
//     - walk_ticks loads 0 on entry, then +1 every TICK_CYCLES, saturating at 2^COUNT_W-1.
//     - walk_light=0 -> LOCKOUT; walk_ticks holds its final value.
//     - Presses are ignored (not queued).
//   - LOCKOUT: count LOCKOUT_CYCLES -> IDLE; walk_ticks clears to 0 on exit.
//     - Presses are ignored.
//     - walk_light=1 re-entry -> WALK.
// - Protocol check, all states:
//   - walk_light == stop_light for 2 consecutive sampled cycles -> fault=1.
//   - A 1-cycle overlap or gap is tolerated as controller skew.
// - fault is sticky until rst_n; the FSM keeps operating normally after a fault.
// - Simultaneous press and walk_light rise in IDLE -> WALK (walk wins); no request issued.
// - Reset mid-walk or mid-wait: immediate return to the reset values above; the pending request is lost.
// - All outputs are registered; no combinational path from btn_raw or the lights to any output.
// STRUCTURE
// - Shared traffic_pkg.vh, also included by the controller:
//   - FSM encodings PED_IDLE=0, PED_WAIT=1, PED_WALK=2, PED_LOCK=3.
//   - Controller phase encodings.
// - Sub-module ped_debounce (params DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw -> btn_db, press).
//   Contains synchroniser, debounce counter and edge detect.
// - Top holds the FSM, the tick/timeout/lockout counters and the protocol checker.
// TESTING
// 1. Reset: rst_n=0 mid-WAIT -> all outputs 0 at once; after release, state IDLE.
// 2. Clean press:
//    btn_raw high 10 cycles, DEBOUNCE=4 -> pedestrian_btn and wait_lamp rise 7 edges later.
//    Then walk_light=1, stop_light=0 -> pedestrian_btn=0 on the next edge.
// 3. Bounce: btn_raw toggles every 2 cycles for 20 cycles -> no press, pedestrian_btn stays 0.
// 4. Walk timing: walk held 40 cycles, TICK=8 -> walk_ticks goes 1,2,3,4,5.
//    Press during walk or lockout -> ignored; IDLE reached after 4 lockout cycles.
// 5. Timeout: request pending 64 cycles with no walk -> fault=1, pedestrian_btn still 1.
// 6. Protocol: walk_light=stop_light=1 for 1 cycle -> no fault; for 2 cycles -> fault=1, sticky.

Source files
------------

// File: rtl/pedestrian_request_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : pedestrian_request_unit_pkg
// Desc   : Shared FSM encodings and sizing helper for the pedestrian unit.
// Rev    : 1.0 - initial release
// ============================================================================
package pedestrian_request_unit_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] PED_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] PED_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] PED_WALK = 2'd2;
  localparam logic [STATE_W-1:0] PED_LOCK = 2'd3;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pedestrian_request_unit_if.sv
`default_nettype none
// ============================================================================
// Module : pedestrian_request_unit_if
// Desc   : Button, controller light and lamp/display signals of the unit.
// Rev    : 1.0 - initial release
// ============================================================================
interface pedestrian_request_unit_if #(
  parameter int COUNT_W = 4
);
  logic               btn_raw;
  logic               walk_light;
  logic               stop_light;
  logic               pedestrian_btn;
  logic               wait_lamp;
  logic [COUNT_W-1:0] walk_ticks;
  logic               fault;

  modport master (
    output btn_raw, walk_light, stop_light,
    input  pedestrian_btn, wait_lamp, walk_ticks, fault
  );

  modport slave (
    input  btn_raw, walk_light, stop_light,
    output pedestrian_btn, wait_lamp, walk_ticks, fault
  );
endinterface
`default_nettype wire

// File: rtl/pedestrian_request_unit_debounce.sv
`default_nettype none
// ============================================================================
// Module : ped_debounce
// Desc   : Button synchroniser, debounce counter and registered press pulse.
// Rev    : 1.0 - initial release
// ============================================================================
module ped_debounce
  import pedestrian_request_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic btn_raw,
  output logic      btn_db,
  output logic      press
);

  localparam int             CNT_W     = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff = r_sync2 ^ r_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      // The level flips on the last of DEBOUNCE_CYCLES consecutive mismatches.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == C_DB_LAST) begin
        r_cnt <= '0;
        r_db  <= ~r_db;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
    end
  end

  assign btn_db = r_db;
  assign press  = r_press;

endmodule
`default_nettype wire

// File: rtl/pedestrian_request_unit.sv
`default_nettype none
// ============================================================================
// Module : pedestrian_request_unit
// Desc   : Kerb-side request FSM with walk display, timeout and light checker.
// Rev    : 1.0 - initial release
// ============================================================================
module pedestrian_request_unit
  import pedestrian_request_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_CYCLES     = 8,
  parameter int COUNT_W         = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int LOCKOUT_CYCLES  = 4
) (
  input wire logic                  clk,
  input wire logic                  rst_n,
  pedestrian_request_unit_if.slave  bus
);

  localparam int              TICK_W      = cnt_width(TICK_CYCLES - 1);
  localparam int              WAIT_W      = cnt_width(TIMEOUT_CYCLES - 1);
  localparam int              LOCK_W      = cnt_width(LOCKOUT_CYCLES - 1);
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] C_LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic                 w_btn_db_unused;
  logic                 w_press;
  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic                 w_req_nxt;
  logic                 r_req;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [COUNT_W-1:0]   r_walk_ticks;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [LOCK_W-1:0]    r_lock_cnt;
  logic                 r_eq_q;
  logic                 r_fault;
  logic                 w_lights_eq;
  logic                 w_timeout;
  logic                 w_lock_done;
  logic                 w_walk_entry;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_raw),
    .btn_db  (w_btn_db_unused),
    .press   (w_press)
  );

  assign w_lights_eq  = (bus.walk_light == bus.stop_light);
  assign w_timeout    = (r_state == PED_WAIT) && (r_wait_cnt == C_WAIT_LAST);
  assign w_lock_done  = (r_lock_cnt == C_LOCK_LAST);
  assign w_walk_entry = (w_state_nxt == PED_WALK) && (r_state != PED_WALK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PED_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Walk always wins over a simultaneous press, so it is tested first.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PED_IDLE: begin
        if (bus.walk_light)   w_state_nxt = PED_WALK;
        else if (w_press)     w_state_nxt = PED_WAIT;
      end
      PED_WAIT: begin
        if (bus.walk_light)   w_state_nxt = PED_WALK;
      end
      PED_WALK: begin
        if (!bus.walk_light)  w_state_nxt = PED_LOCK;
      end
      PED_LOCK: begin
        if (bus.walk_light)   w_state_nxt = PED_WALK;
        else if (w_lock_done) w_state_nxt = PED_IDLE;
      end
      default:                w_state_nxt = PED_IDLE;
    endcase
  end

  always_comb begin
    w_req_nxt = (w_state_nxt == PED_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req        <= 1'b0;
      r_tick_cnt   <= '0;
      r_walk_ticks <= '0;
      r_wait_cnt   <= '0;
      r_lock_cnt   <= '0;
      r_eq_q       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_req <= w_req_nxt;

      // The display keeps its last value through lockout and clears on return to idle.
      if (w_walk_entry) begin
        r_tick_cnt   <= '0;
        r_walk_ticks <= '0;
      end else if (r_state == PED_WALK) begin
        if (r_tick_cnt == C_TICK_LAST) begin
          r_tick_cnt <= '0;
          if (r_walk_ticks != '1) r_walk_ticks <= r_walk_ticks + 1'b1;
        end else begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end else if ((r_state == PED_LOCK) && (w_state_nxt == PED_IDLE)) begin
        r_walk_ticks <= '0;
      end

      if (r_state != PED_WAIT)            r_wait_cnt <= '0;
      else if (r_wait_cnt != C_WAIT_LAST) r_wait_cnt <= r_wait_cnt + 1'b1;

      if (r_state != PED_LOCK)            r_lock_cnt <= '0;
      else if (!w_lock_done)              r_lock_cnt <= r_lock_cnt + 1'b1;

      // One sampled cycle of equal lights is controller skew; two is a fault.
      r_eq_q  <= w_lights_eq;
      r_fault <= r_fault | (w_lights_eq & r_eq_q) | w_timeout;
    end
  end

  assign bus.pedestrian_btn = r_req;
  assign bus.wait_lamp      = r_req;
  assign bus.walk_ticks     = r_walk_ticks;
  assign bus.fault          = r_fault;

endmodule
`default_nettype wire
